// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// EX-stage branch resolver and the update side of the gshare/BTB predictor.
// It works out the real next PC of the instruction in EX and compares it with
// the PC the predictor chose at fetch time. On a mismatch it redirects fetch
// and squashes IF/ID and ID/EX in the same cycle. One cycle later it sends a
// registered update packet to the predictor. It also keeps saturating counts
// of resolved control instructions and of mispredicts.
//
// Ports
//   clk, rst              clock; synchronous active-low reset (0 = reset)
//   ex_valid, ex_stall    EX holds a real instruction / EX frozen this cycle
//   ex_is_branch/jal/jalr control-instruction class (one-hot or none)
//   ex_br_cond            ALU compare result for conditional branches
//   ex_pc, ex_pred_pc     PC of the EX instruction / predicted next PC
//   ex_imm, ex_rs1_data   sign-extended immediate / forwarded JALR base
//   redirect_valid/pc     combinational fetch redirect on mispredict
//   flush_if_id/id_ex     combinational pipeline squash on mispredict
//   update_pred           registered one-cycle predictor update strobe
//   branch_inst_address   registered PC of the resolved control instruction
//   resolved_next_pc      registered actual next PC
//   predictor_wrong       registered mispredict flag for the update
//   branch_count          saturating count of resolved control instructions
//   mispredict_count      saturating count of mispredicted control instrs
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jal,
  input  logic                 ex_is_jalr,
  input  logic                 ex_br_cond,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_pred_pc,
  input  logic [31:0]          ex_imm,
  input  logic [31:0]          ex_rs1_data,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 update_pred,
  output logic [31:0]          branch_inst_address,
  output logic [31:0]          resolved_next_pc,
  output logic                 predictor_wrong,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] value,
    input logic                 en
  );
    if (en && (value != {CNT_WIDTH{1'b1}}))
      return value + CNT_WIDTH'(1);
    return value;
  endfunction

  // JALR targets always have bit 0 cleared.
  function automatic logic [31:0] clear_lsb(input logic signed [31:0] addr);
    return 32'(addr) & 32'hFFFF_FFFE;
  endfunction

  state_t state;

  logic signed [31:0] pc_s;
  logic signed [31:0] imm_s;
  logic signed [31:0] rs1_s;
  logic signed [31:0] target_s;
  logic signed [31:0] jalr_sum_s;
  logic [31:0]        seq_pc;
  logic [31:0]        actual_pc;

  logic active;
  logic resolve;
  logic ctrl;
  logic mispredict;
  logic do_update;

  logic                 vld_p1;
  logic [31:0]          addr_p1;
  logic [31:0]          next_pc_p1;
  logic                 wrong_p1;
  logic [CNT_WIDTH-1:0] br_cnt;
  logic [CNT_WIDTH-1:0] mis_cnt;

  // ---- stage p0: resolve in EX (combinational) ----
  assign pc_s       = ex_pc;
  assign imm_s      = ex_imm;
  assign rs1_s      = ex_rs1_data;
  assign target_s   = pc_s + imm_s;
  assign jalr_sum_s = rs1_s + imm_s;
  assign seq_pc     = ex_pc + 32'd4;

  always_comb begin
    actual_pc = seq_pc;
    if (ex_is_jalr)
      actual_pc = clear_lsb(jalr_sum_s);
    else if (ex_is_jal)
      actual_pc = 32'(target_s);
    else if (ex_is_branch && ex_br_cond)
      actual_pc = 32'(target_s);
  end

  // While in reset or recovering, EX holds nothing we may act on.
  assign active     = rst && (state == NORMAL);
  assign resolve    = active && ex_valid && !ex_stall;
  assign ctrl       = ex_is_branch || ex_is_jal || ex_is_jalr;
  // Non-control instructions can mispredict too when the BTB aliases.
  assign mispredict = resolve && (actual_pc != ex_pred_pc);
  assign do_update  = resolve && ctrl;

  assign redirect_valid = mispredict;
  assign flush_if_id    = mispredict;
  assign flush_id_ex    = mispredict;
  assign redirect_pc    = active ? actual_pc : 32'd0;

  // ---- recovery FSM ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= NORMAL;
    end else begin
      case (state)
        NORMAL:  if (mispredict) state <= RECOVER;
        RECOVER: state <= NORMAL;
        default: state <= NORMAL;
      endcase
    end
  end

  // ---- stage p1: registered predictor update and statistics ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      addr_p1    <= 32'd0;
      next_pc_p1 <= 32'd0;
      wrong_p1   <= 1'b0;
      br_cnt     <= '0;
      mis_cnt    <= '0;
    end else begin
      vld_p1 <= do_update;
      if (do_update) begin
        addr_p1    <= ex_pc;
        next_pc_p1 <= actual_pc;
        wrong_p1   <= mispredict;
      end
      br_cnt  <= sat_inc(br_cnt, do_update);
      mis_cnt <= sat_inc(mis_cnt, do_update && mispredict);
    end
  end

  assign update_pred         = vld_p1;
  assign branch_inst_address = addr_p1;
  assign resolved_next_pc    = next_pc_p1;
  assign predictor_wrong     = wrong_p1;
  assign branch_count        = br_cnt;
  assign mispredict_count    = mis_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit (CNT_WIDTH=4). Stimulus tasks push
// the expected predictor update packet into a queue; a monitor pops and
// compares whenever the DUT raises update_pred.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int CW = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] npc;
    logic        wrong;
  } upd_t;

  logic          clk;
  logic          rst;
  logic          ex_valid;
  logic          ex_stall;
  logic          ex_is_branch;
  logic          ex_is_jal;
  logic          ex_is_jalr;
  logic          ex_br_cond;
  logic [31:0]   ex_pc;
  logic [31:0]   ex_pred_pc;
  logic [31:0]   ex_imm;
  logic [31:0]   ex_rs1_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic          update_pred;
  logic [31:0]   branch_inst_address;
  logic [31:0]   resolved_next_pc;
  logic          predictor_wrong;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  upd_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  branch_resolve_unit #(.CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_valid            (ex_valid),
    .ex_stall            (ex_stall),
    .ex_is_branch        (ex_is_branch),
    .ex_is_jal           (ex_is_jal),
    .ex_is_jalr          (ex_is_jalr),
    .ex_br_cond          (ex_br_cond),
    .ex_pc               (ex_pc),
    .ex_pred_pc          (ex_pred_pc),
    .ex_imm              (ex_imm),
    .ex_rs1_data         (ex_rs1_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .flush_if_id         (flush_if_id),
    .flush_id_ex         (flush_id_ex),
    .update_pred         (update_pred),
    .branch_inst_address (branch_inst_address),
    .resolved_next_pc    (resolved_next_pc),
    .predictor_wrong     (predictor_wrong),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every update pulse must match the oldest expected packet.
  always @(negedge clk) begin
    if (update_pred === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_update", 32'd1, 32'd0);
      end else begin
        upd_t e;
        e = exp_q.pop_front();
        chk("upd_addr", branch_inst_address, e.addr);
        chk("upd_npc", resolved_next_pc, e.npc);
        chk("upd_wrong", 32'(predictor_wrong), 32'(e.wrong));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic set_ex(input logic v, input logic st, input logic br, input logic jal,
                        input logic jalr, input logic cond, input logic [31:0] pc,
                        input logic [31:0] pred, input logic [31:0] imm,
                        input logic [31:0] rs1);
    ex_valid     = v;
    ex_stall     = st;
    ex_is_branch = br;
    ex_is_jal    = jal;
    ex_is_jalr   = jalr;
    ex_br_cond   = cond;
    ex_pc        = pc;
    ex_pred_pc   = pred;
    ex_imm       = imm;
    ex_rs1_data  = rs1;
  endtask

  // Drive one EX op for a cycle, check the combinational response, and queue
  // the expected update packet (actual next PC, wrong = exp_redir).
  task automatic issue(input string name, input logic br, input logic jal,
                       input logic jalr, input logic cond, input logic [31:0] pc,
                       input logic [31:0] pred, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic stall,
                       input logic exp_redir, input logic [31:0] exp_pc,
                       input logic exp_upd);
    upd_t e;
    set_ex(1'b1, stall, br, jal, jalr, cond, pc, pred, imm, rs1);
    #1;
    chk({name, "_redir"}, 32'(redirect_valid), 32'(exp_redir));
    chk({name, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, {30'd0, exp_redir, exp_redir});
    if (exp_redir) chk({name, "_rpc"}, redirect_pc, exp_pc);
    if (exp_upd) begin
      e.addr  = pc;
      e.npc   = exp_pc;
      e.wrong = exp_redir;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input int br, input int mis);
    chk({name, "_bcnt"}, 32'(branch_count), 32'(br));
    chk({name, "_mcnt"}, 32'(mispredict_count), 32'(mis));
  endtask

  initial begin
    // Reset with a mispredicting op in EX: nothing may come out.
    rst = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h500, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_redir", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_upd", 32'(update_pred), 32'd0);
    chk("rst_addr", branch_inst_address, 32'd0);
    chk("rst_npc", resolved_next_pc, 32'd0);
    chk("rst_wrong", 32'(predictor_wrong), 32'd0);
    chk_cnt("rst", 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();

    // 1: correctly predicted taken BEQ
    issue("beq_ok", 1, 0, 0, 1, 32'h100, 32'h140, 32'h40, 32'd0, 0, 0, 32'h140, 1);
    idle();
    chk_cnt("t1", 1, 0);

    // 2: BNE backward, predicted not-taken; then a wrong-path JAL in RECOVER
    issue("bne_mis", 1, 0, 0, 1, 32'h200, 32'h204, 32'hFFFF_FFF8, 32'd0, 0, 1, 32'h1F8, 1);
    issue("recover", 0, 1, 0, 0, 32'h400, 32'h0, 32'h8, 32'd0, 0, 0, 32'h408, 0);
    idle();
    chk_cnt("t2", 2, 1);

    // 3: JALR with odd base, correct then wrong prediction
    issue("jalr_ok", 0, 0, 1, 0, 32'h600, 32'h1010, 32'h10, 32'h1001, 0, 0, 32'h1010, 1);
    issue("jalr_mis", 0, 0, 1, 0, 32'h600, 32'h1014, 32'h10, 32'h1001, 0, 1, 32'h1010, 1);
    idle();
    chk_cnt("t3", 4, 2);

    // 4: non-control op hit by a BTB alias
    issue("alias", 0, 0, 0, 0, 32'h300, 32'h500, 32'd0, 32'd0, 0, 1, 32'h304, 0);
    idle();
    chk_cnt("t4", 4, 2);

    // 5: mispredicting BEQ held by a 3-cycle stall, then released
    for (int i = 0; i < 3; i++)
      issue("stall", 1, 0, 0, 1, 32'h700, 32'h704, 32'h20, 32'd0, 1, 0, 32'h720, 0);
    issue("stall_rel", 1, 0, 0, 1, 32'h700, 32'h704, 32'h20, 32'd0, 0, 1, 32'h720, 1);
    idle();
    chk_cnt("t5", 5, 3);

    // Back-to-back correctly predicted JAL then not-taken BEQ
    issue("b2b_jal", 0, 1, 0, 0, 32'h800, 32'h900, 32'h100, 32'd0, 0, 0, 32'h900, 1);
    issue("b2b_beq", 1, 0, 0, 0, 32'h900, 32'h904, 32'h8, 32'd0, 0, 0, 32'h904, 1);
    idle();
    chk_cnt("b2b", 7, 3);

    // 6: drive both counters to saturation, then one more mispredict
    for (int i = 0; i < 12; i++) begin
      issue("sat_fill", 1, 0, 0, 0, 32'hA00, 32'hA40, 32'h40, 32'd0, 0, 1, 32'hA04, 1);
      idle();
    end
    chk_cnt("sat_full", 15, 15);
    issue("sat_more", 1, 0, 0, 0, 32'hA00, 32'hA40, 32'h40, 32'd0, 0, 1, 32'hA04, 1);
    chk_cnt("sat_hold", 15, 15);

    // Reset asserted during RECOVER with a mispredicting op in EX
    rst = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h500, 32'd0, 32'd0);
    #1;
    chk("rr_redir", 32'(redirect_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rr_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    chk("rr_rpc", redirect_pc, 32'd0);
    chk("rr_upd", 32'(update_pred), 32'd0);
    chk("rr_addr", branch_inst_address, 32'd0);
    chk("rr_npc", resolved_next_pc, 32'd0);
    chk("rr_wrong", 32'(predictor_wrong), 32'd0);
    chk_cnt("rr", 0, 0);
    rst = 1'b1;

    // Back in NORMAL: an alias mispredict must redirect immediately
    issue("post_rst", 0, 0, 0, 0, 32'h300, 32'h500, 32'd0, 32'd0, 0, 1, 32'h304, 0);
    idle();
    idle();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
